// File: rtl/sauria_demo_pkg.sv
// Shared definitions for the SAURIA demo integration: AXI4-Lite response
// codes and protection attributes used by the configuration bridges.
package sauria_demo_pkg;

   localparam logic [1:0] AxiRespOkay   = 2'b00;
   localparam logic [1:0] AxiRespExOkay = 2'b01;
   localparam logic [1:0] AxiRespSlvErr = 2'b10;
   localparam logic [1:0] AxiRespDecErr = 2'b11;

   localparam logic [2:0] AxiProtDefault = 3'b000;

   // SLVERR and DECERR both map onto the single register-interface error bit.
   function automatic logic axi_resp_is_err(input logic [1:0] resp);
      logic is_err;
      case (resp)
         AxiRespSlvErr, AxiRespDecErr: is_err = 1'b1;
         AxiRespOkay, AxiRespExOkay:   is_err = 1'b0;
         default:                      is_err = 1'b0;
      endcase
      return is_err;
   endfunction

endpackage

// File: rtl/sauria_reg_to_axil.sv
// Register-interface to AXI4-Lite bridge: latches one request, replays it as a
// single AXI-Lite write or read, and returns the response as a one-cycle pulse.
module sauria_reg_to_axil
   import sauria_demo_pkg::*;
#(
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          DataWidth = 32,
   parameter logic [AddrWidth-1:0] AddrMask  = 32'h0000_FFFF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,

   input  logic                   reg_valid_i,
   input  logic                   reg_write_i,
   input  logic [AddrWidth-1:0]   reg_addr_i,
   input  logic [DataWidth-1:0]   reg_wdata_i,
   input  logic [DataWidth/8-1:0] reg_wstrb_i,
   output logic                   reg_ready_o,
   output logic [DataWidth-1:0]   reg_rdata_o,
   output logic                   reg_error_o,

   output logic                   axil_aw_valid_o,
   input  logic                   axil_aw_ready_i,
   output logic [AddrWidth-1:0]   axil_aw_addr_o,
   output logic [2:0]             axil_aw_prot_o,

   output logic                   axil_w_valid_o,
   input  logic                   axil_w_ready_i,
   output logic [DataWidth-1:0]   axil_w_data_o,
   output logic [DataWidth/8-1:0] axil_w_strb_o,

   input  logic                   axil_b_valid_i,
   output logic                   axil_b_ready_o,
   input  logic [1:0]             axil_b_resp_i,

   output logic                   axil_ar_valid_o,
   input  logic                   axil_ar_ready_i,
   output logic [AddrWidth-1:0]   axil_ar_addr_o,
   output logic [2:0]             axil_ar_prot_o,

   input  logic                   axil_r_valid_i,
   output logic                   axil_r_ready_o,
   input  logic [DataWidth-1:0]   axil_r_data_i,
   input  logic [1:0]             axil_r_resp_i
);

   typedef enum logic [2:0] {
      Idle   = 3'd0,
      WrReq  = 3'd1,
      WrResp = 3'd2,
      RdReq  = 3'd3,
      RdResp = 3'd4,
      Done   = 3'd5
   } sauria_reg_to_axil_state_e;

   sauria_reg_to_axil_state_e state_q;

   logic [AddrWidth-1:0]   addr_q;
   logic [DataWidth-1:0]   wdata_q;
   logic [DataWidth/8-1:0] wstrb_q;
   logic [DataWidth-1:0]   rdata_q;
   logic                   error_q;
   logic                   aw_pend_q;
   logic                   w_pend_q;
   logic                   ar_pend_q;

   // A pending flag survives this cycle only if its handshake does not complete now.
   logic aw_pend_next;
   logic w_pend_next;

   always_comb begin
      aw_pend_next = aw_pend_q && !axil_aw_ready_i;
      w_pend_next  = w_pend_q && !axil_w_ready_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= Idle;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         error_q   <= 1'b0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
         ar_pend_q <= 1'b0;
      end else begin
         case (state_q)
            Idle: begin
               if (reg_valid_i) begin
                  addr_q    <= reg_addr_i & AddrMask;
                  wdata_q   <= reg_wdata_i;
                  wstrb_q   <= reg_wstrb_i;
                  aw_pend_q <= reg_write_i;
                  w_pend_q  <= reg_write_i;
                  ar_pend_q <= !reg_write_i;
                  state_q   <= reg_write_i ? WrReq : RdReq;
               end
            end
            WrReq: begin
               aw_pend_q <= aw_pend_next;
               w_pend_q  <= w_pend_next;
               if (!aw_pend_next && !w_pend_next) begin
                  state_q <= WrResp;
               end
            end
            WrResp: begin
               if (axil_b_valid_i) begin
                  rdata_q <= '0;
                  error_q <= axi_resp_is_err(axil_b_resp_i);
                  state_q <= Done;
               end
            end
            RdReq: begin
               if (axil_ar_ready_i) begin
                  ar_pend_q <= 1'b0;
                  state_q   <= RdResp;
               end
            end
            RdResp: begin
               if (axil_r_valid_i) begin
                  rdata_q <= axil_r_data_i;
                  error_q <= axi_resp_is_err(axil_r_resp_i);
                  state_q <= Done;
               end
            end
            Done: begin
               state_q <= Idle;
            end
            default: begin
               state_q <= Idle;
            end
         endcase
      end
   end

   // Every output is a register or a decode of state, so no input-to-output paths exist.
   always_comb begin
      reg_ready_o     = (state_q == Done);
      reg_rdata_o     = rdata_q;
      reg_error_o     = error_q;

      axil_aw_valid_o = (state_q == WrReq) && aw_pend_q;
      axil_aw_addr_o  = addr_q;
      axil_aw_prot_o  = AxiProtDefault;

      axil_w_valid_o  = (state_q == WrReq) && w_pend_q;
      axil_w_data_o   = wdata_q;
      axil_w_strb_o   = wstrb_q;

      axil_b_ready_o  = (state_q == WrResp);

      axil_ar_valid_o = (state_q == RdReq) && ar_pend_q;
      axil_ar_addr_o  = addr_q;
      axil_ar_prot_o  = AxiProtDefault;

      axil_r_ready_o  = (state_q == RdResp);
   end

endmodule
